// File: rtl/fact_mmio_pkg.sv
// Shared register-map constants for the factorial MMIO control front-end.
package fact_mmio_pkg;

  localparam logic [1:0] REG_N      = 2'd0;
  localparam logic [1:0] REG_GO     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

endpackage

// File: rtl/fact_mmio_chan.sv
// One factorial channel: operand, launch pulse, busy tracking, sticky status
// flags and result capture.
module fact_mmio_chan
  import fact_mmio_pkg::*;
#(
  parameter int NW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_n,
  input  logic          wr_go,
  input  logic          wr_status,
  input  logic [NW-1:0] wd_n,
  input  logic [1:0]    wd_ctl,
  input  logic          done_in,
  input  logic          err_in,
  input  logic [DW-1:0] result_in,
  output logic [NW-1:0] n_out,
  output logic          go_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          err_out,
  output logic          flag_next,
  output logic [DW-1:0] result_out
);

  logic [NW-1:0] n_q, n_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] result_q, result_d;
  logic          launch_s;
  logic          finish_s;

  assign launch_s = wr_go && wd_ctl[0] && !busy_q;
  assign finish_s = busy_q && (done_in || err_in);

  // Next-state: set events from the core take priority over W1C clears.
  always_comb begin
    n_d      = n_q;
    go_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;

    if (wr_n && !busy_q) n_d = wd_n;
    else                 n_d = n_q;

    if (launch_s) begin
      go_d   = 1'b1;
      busy_d = 1'b1;
    end else if (finish_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    if (busy_q && done_in)                      done_d = 1'b1;
    else if (wr_status && wd_ctl[STAT_DONE])    done_d = 1'b0;
    else                                        done_d = done_q;

    if (busy_q && err_in)                       err_d = 1'b1;
    else if (wr_status && wd_ctl[STAT_ERR])     err_d = 1'b0;
    else                                        err_d = err_q;

    if (busy_q && done_in) result_d = result_in;
    else                   result_d = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= {NW{1'b0}};
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= {DW{1'b0}};
    end else begin
      n_q      <= n_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign n_out      = n_q;
  assign go_out     = go_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign err_out    = err_q;
  assign flag_next  = done_d || err_d;
  assign result_out = result_q;

endmodule

// File: rtl/fact_mmio_ctrl.sv
// MMIO front-end for NCH factorial cores: address decode, per-channel write
// fan-out, registered read mux and registered interrupt.
module fact_mmio_ctrl
  import fact_mmio_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int NW  = 4,
  parameter  int DW  = 32,
  localparam int AW  = $clog2(NCH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wd,
  output logic [DW-1:0]     rd,
  output logic [NCH*NW-1:0] n_out,
  output logic [NCH-1:0]    go_out,
  input  logic [NCH-1:0]    done_in,
  input  logic [NCH-1:0]    err_in,
  input  logic [NCH*DW-1:0] result_in,
  output logic              irq
);

  localparam int CW = AW - 2;

  logic [CW-1:0]  chan_s;
  logic [1:0]     reg_s;
  logic [NCH-1:0] busy_s, done_s, err_s, flag_next_s;
  logic [NW-1:0]  n_a      [NCH];
  logic [DW-1:0]  result_a [NCH];
  logic [DW-1:0]  rd_q, rd_d;
  logic           irq_q, irq_d;
  logic           wd_unused_s;

  assign chan_s      = addr[AW-1:2];
  assign reg_s       = addr[1:0];
  assign wd_unused_s = ^wd[DW-1:NW];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    localparam logic [CW-1:0] CH = CW'(c);
    logic sel_s;
    assign sel_s = we && (chan_s == CH);

    fact_mmio_chan #(.NW(NW), .DW(DW)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_n       (sel_s && (reg_s == REG_N)),
      .wr_go      (sel_s && (reg_s == REG_GO)),
      .wr_status  (sel_s && (reg_s == REG_STATUS)),
      .wd_n       (wd[NW-1:0]),
      .wd_ctl     (wd[1:0]),
      .done_in    (done_in[c]),
      .err_in     (err_in[c]),
      .result_in  (result_in[c*DW +: DW]),
      .n_out      (n_a[c]),
      .go_out     (go_out[c]),
      .busy_out   (busy_s[c]),
      .done_out   (done_s[c]),
      .err_out    (err_s[c]),
      .flag_next  (flag_next_s[c]),
      .result_out (result_a[c])
    );

    assign n_out[c*NW +: NW] = n_a[c];
  end

  // Read mux uses current register values, so a same-cycle write reads old data.
  always_comb begin
    rd_d = {DW{1'b0}};
    case (reg_s)
      REG_N:      rd_d[NW-1:0] = n_a[chan_s];
      REG_GO:     rd_d[0]      = busy_s[chan_s];
      REG_STATUS: begin
        rd_d[STAT_DONE] = done_s[chan_s];
        rd_d[STAT_ERR]  = err_s[chan_s];
      end
      REG_RESULT: rd_d = result_a[chan_s];
      default:    rd_d = {DW{1'b0}};
    endcase
    irq_d = |flag_next_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= {DW{1'b0}};
      irq_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      irq_q <= irq_d;
    end
  end

  assign rd  = rd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_fact_mmio_ctrl.sv
// Scoreboard bench for fact_mmio_ctrl: expected read data is queued when a
// read address is driven and compared when rd returns one cycle later.
module tb_fact_mmio_ctrl;

  localparam int NCH = 4;
  localparam int NW  = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;

  localparam logic [1:0] R_N = 2'd0, R_GO = 2'd1, R_ST = 2'd2, R_RES = 2'd3;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wd;
  logic [DW-1:0]     rd;
  logic [NCH*NW-1:0] n_out;
  logic [NCH-1:0]    go_out;
  logic [NCH-1:0]    done_in;
  logic [NCH-1:0]    err_in;
  logic [NCH*DW-1:0] result_in;
  logic              irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fact_mmio_ctrl #(.NCH(NCH), .NW(NW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .n_out     (n_out),
    .go_out    (go_out),
    .done_in   (done_in),
    .err_in    (err_in),
    .result_in (result_in),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d);
    we   = 1'b1;
    addr = {ch, r};
    wd   = d;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] ch, input logic [1:0] r,
                        input logic [31:0] e, input string tag);
    exp_t x;
    we   = 1'b0;
    addr = {ch, r};
    sb.push_back('{tag, e});
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_eq(x.tag, rd, x.exp);
    end
  endtask

  task automatic core_evt(input logic [1:0] ch, input logic d, input logic e,
                          input logic [31:0] res);
    done_in = {NCH{1'b0}};
    err_in  = {NCH{1'b0}};
    done_in[ch] = d;
    err_in[ch]  = e;
    result_in[ch*DW +: DW] = res;
    @(negedge clk);
    done_in   = {NCH{1'b0}};
    err_in    = {NCH{1'b0}};
    result_in = {NCH*DW{1'b0}};
  endtask

  initial begin
    exp_t x;
    rst_n = 1'b0; we = 1'b0; addr = {AW{1'b0}}; wd = 32'd0;
    done_in = {NCH{1'b0}}; err_in = {NCH{1'b0}}; result_in = {NCH*DW{1'b0}};

    repeat (3) @(negedge clk);
    check_eq("rst_rd", rd, 32'd0);
    check_eq("rst_go", {28'd0, go_out}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      logic [3:0] av;
      av = 4'(a);
      rd_chk(av[3:2], av[1:0], 32'd0, $sformatf("rst_reg%0d", a));
    end

    // Launch on channel 2.
    wr(2'd2, R_N, 32'd5);
    wr(2'd2, R_GO, 32'd1);
    check_eq("ch2_go_pulse", {28'd0, go_out}, 32'h4);
    rd_chk(2'd2, R_GO, 32'd1, "ch2_busy");
    check_eq("ch2_go_single", {28'd0, go_out}, 32'h0);
    rd_chk(2'd2, R_N, 32'd5, "ch2_n");
    check_eq("ch2_n_out", {16'd0, n_out}, 32'h0500);
    core_evt(2'd2, 1'b1, 1'b0, 32'd120);
    check_eq("ch2_irq", {31'd0, irq}, 32'd1);
    rd_chk(2'd2, R_ST, 32'd1, "ch2_status");
    rd_chk(2'd2, R_RES, 32'd120, "ch2_result");
    rd_chk(2'd2, R_GO, 32'd0, "ch2_idle");

    // Busy protection on channel 1.
    wr(2'd1, R_N, 32'd3);
    wr(2'd1, R_GO, 32'd1);
    check_eq("ch1_go_pulse", {28'd0, go_out}, 32'h2);
    wr(2'd1, R_N, 32'd7);
    wr(2'd1, R_GO, 32'd1);
    check_eq("ch1_no_relaunch", {28'd0, go_out}, 32'h0);
    rd_chk(2'd1, R_N, 32'd3, "ch1_n_kept");
    rd_chk(2'd1, R_GO, 32'd1, "ch1_still_busy");
    core_evt(2'd1, 1'b1, 1'b0, 32'd6);
    rd_chk(2'd1, R_RES, 32'd6, "ch1_result");

    // Error path on channel 0.
    wr(2'd0, R_N, 32'd13);
    wr(2'd0, R_GO, 32'd1);
    core_evt(2'd0, 1'b0, 1'b1, 32'hDEAD);
    rd_chk(2'd0, R_ST, 32'd2, "ch0_err_status");
    rd_chk(2'd0, R_RES, 32'd0, "ch0_result_kept");
    wr(2'd2, R_ST, 32'd1);
    wr(2'd1, R_ST, 32'd1);
    check_eq("irq_err_only", {31'd0, irq}, 32'd1);
    wr(2'd0, R_ST, 32'd2);
    check_eq("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk(2'd0, R_ST, 32'd0, "ch0_w1c");
    rd_chk(2'd0, R_RES, 32'hFFFF_FFFF & 32'd0, "ch0_res_ro_pre");
    wr(2'd0, R_RES, 32'h1234);
    rd_chk(2'd0, R_RES, 32'd0, "ch0_res_ro");

    // Read in the same cycle as a write returns the old value.
    we = 1'b1; addr = {2'd0, R_N}; wd = 32'hFFF9;
    sb.push_back('{"rw_same_old", 32'd13});
    @(negedge clk);
    we = 1'b0;
    x = sb.pop_front();
    check_eq(x.tag, rd, x.exp);
    rd_chk(2'd0, R_N, 32'd9, "rw_new");

    // W1C race and earliest relaunch on channel 3.
    wr(2'd3, R_N, 32'd4);
    wr(2'd3, R_GO, 32'd1);
    we = 1'b1; addr = {2'd3, R_ST}; wd = 32'd1;
    core_evt(2'd3, 1'b1, 1'b0, 32'd24);
    we = 1'b0;
    wr(2'd3, R_GO, 32'd1);
    check_eq("ch3_relaunch", {28'd0, go_out}, 32'h8);
    rd_chk(2'd3, R_ST, 32'd1, "ch3_race_done");
    rd_chk(2'd3, R_RES, 32'd24, "ch3_result");
    rd_chk(2'd3, R_GO, 32'd1, "ch3_busy2");
    core_evt(2'd3, 1'b1, 1'b1, 32'd99);
    rd_chk(2'd3, R_ST, 32'd3, "ch3_both_flags");
    rd_chk(2'd3, R_RES, 32'd99, "ch3_both_result");
    check_eq("ch3_irq", {31'd0, irq}, 32'd1);

    // Reset in the middle of a channel 1 job.
    wr(2'd1, R_GO, 32'd1);
    check_eq("ch1_mid_go", {28'd0, go_out}, 32'h2);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_go", {28'd0, go_out}, 32'h0);
    check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_evt(2'd1, 1'b1, 1'b0, 32'd77);
    rd_chk(2'd1, R_ST, 32'd0, "post_rst_status");
    rd_chk(2'd1, R_RES, 32'd0, "post_rst_result");
    rd_chk(2'd1, R_GO, 32'd0, "post_rst_busy");
    rd_chk(2'd0, R_N, 32'd0, "post_rst_n");
    check_eq("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
